stageif_q: RTL and testbench
============================

# stageif_q

Parametrised instruction-fetch stage for the pipelined RISC-V core. It holds the PC, drives the instruction memory address, and captures each fetched instruction together with its PC into a small in-order fetch queue. Decode drains the queue through a valid/ready handshake. A redirect from EX flushes the queue and reloads the PC, so decode back-pressure no longer has to freeze the PC directly.

## Interface
- `XLEN`, default 32: PC and address width.
- `DEPTH`, default 4: fetch-queue entries; must be a power of two and ≥ 2.
- `RESET_PC`, default `'0`: PC value loaded on reset.
- `i_clk` in 1: the single clock; all state updates on its rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_enable` in 1: fetch enable; when 0, no new fetch and the PC holds.
- `i_redirect` in 1: taken branch or jump from EX (the old `pc_sel_ex`).
- `i_redirect_pc` in XLEN: redirect target (the old `alu_data`); bits [1:0] ignored and treated as 00.
- `o_imem_addr` out XLEN: equals the current PC.
- `i_imem_inst` in 32: combinational instruction-memory read data for `o_imem_addr`.
- `o_valid` out 1: head entry available to decode.
- `i_ready` in 1: decode accepts the head.
- `o_instr` out 32: head instruction.
- `o_pc` out XLEN: head PC.
- `o_pc_four` out XLEN: `o_pc + 4`, modulo 2^XLEN.
- `o_count` out $clog2(DEPTH+1): number of queue occupants.

## Operation
- **pop** = `o_valid && i_ready && !i_redirect`.
- **push** = `i_enable && !i_redirect && (count < DEPTH || pop)`. Push writes {PC, `i_imem_inst`} at the write pointer; the PC becomes PC+4, wrapping modulo 2^XLEN.
- A push while full is legal only with a simultaneous pop; `o_count` then stays at DEPTH.
- **Redirect** has priority over everything:
  - Count and both pointers go to 0.
  - PC becomes {`i_redirect_pc`[XLEN-1:2], 2'b00}.
  - No push and no pop that cycle.
  - `o_valid` is forced to 0 combinationally during the redirect cycle.
- `i_enable` = 0: no push, PC holds; pops continue.
- Pointers wrap modulo DEPTH. The queue never reorders and never drops an entry except on redirect or reset.
- `o_valid` = (count ≠ 0) && !`i_redirect`. `o_instr`, `o_pc` and `o_pc_four` always show the entry at the read pointer.

## Timing
- **Reset values** (asynchronous): PC = RESET_PC, count = 0, pointers = 0, all storage = 0. After reset, `o_valid` = 0, `o_instr` = 0, `o_pc` = 0, `o_pc_four` = 4, `o_count` = 0, `o_imem_addr` = RESET_PC.
- Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.
- **Fetch-to-decode latency** without bypass: an instruction fetched in cycle N is visible on `o_valid` in cycle N+1.
- **Redirect latency:** asserted in cycle N → `o_imem_addr` equals the target in cycle N+1 → the target instruction is on `o_valid` in cycle N+2.
- Steady state with `i_ready` = 1 and `i_enable` = 1: one instruction per cycle, count stays at 1.

## Configuration
- **`STAGEIF_BYPASS_EN` defined:** when count = 0, `i_enable` = 1 and `i_redirect` = 0:
  - The fetched instruction is presented in the same cycle: `o_valid` = 1, `o_instr` = `i_imem_inst`, `o_pc` = PC.
  - If `i_ready` = 1, it is consumed without being written to the queue, and the PC advances.
  - If `i_ready` = 0, it is enqueued normally.
  - Fetch-to-decode latency becomes 0 cycles when the queue is empty; redirect latency becomes target-valid in cycle N+1.
- **Macro undefined:** no combinational path from `i_imem_inst` to the outputs; behaviour is exactly as in Operation and Timing.

## Structure
- Package `stageif_pkg` holds:
  - typedef `fetch_entry_t` = {pc[XLEN-1:0], instr[31:0]};
  - `INSTR_NOP` = 32'h0000_0013;
  - `ILEN` = 32;
  - `PC_STEP` = 4.
- Sub-module `fetch_fifo`, parametrised by DEPTH and the entry type. It owns the storage, pointers, count and flush, with push/pop/flush inputs and head/count outputs.
- The top level owns the PC register, the push/pop/redirect arbitration and the bypass mux.

## Test plan
- **Reset:** assert `i_reset` with RESET_PC = 32'h100 → `o_imem_addr` = 32'h100, `o_valid` = 0, `o_count` = 0, `o_pc_four` = 4.
- **Streaming:** `i_enable` = 1, `i_ready` = 1, imem returns the address as data → decode receives PCs 0, 4, 8, … on consecutive cycles, with `o_instr` = `o_pc`.
- **Back-pressure:** `i_ready` = 0 for 6 cycles from reset → `o_count` saturates at 4, PC holds at 32'h10. With `i_ready` = 1 and `i_enable` = 1 while full, `o_count` stays at 4 and pop/push proceed together.
- **Redirect mid-stream:** with count = 3, redirect to 32'h203 → same cycle `o_valid` = 0; next cycle `o_count` = 0 and `o_imem_addr` = 32'h200; the following cycle `o_pc` = 32'h200.
- **Wrap-around:** XLEN = 32, redirect to 32'hFFFF_FFFC → next fetched PC after it is 32'h0, and `o_pc_four` of the head = 0.
- **Bypass (`STAGEIF_BYPASS_EN`):** empty queue, `i_ready` = 1 → `o_valid` = 1 in the fetch cycle with `o_pc` = current PC, and `o_count` stays at 0.

Source files
------------

// File: rtl/stageif_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stageif_pkg;

    localparam int ILEN     = 32;
    localparam int PC_STEP  = 4;
    localparam int XLEN_DEF = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    // Fetch-queue entry for the default 32-bit core; the top level builds the
    // same layout locally when XLEN is overridden.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN-1:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/stageif_q_fetch_fifo.sv
// In-order fetch queue: storage, read/write pointers, occupancy count and
// flush. DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import stageif_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  entry_t           i_wdata,
    output entry_t           o_head,
    output logic [CNT_W-1:0] o_count
);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for storage, pointers and count; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears storage so the head reads as zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/stageif_q.sv
// Instruction-fetch stage: PC register, imem address, fetch queue towards
// decode with a valid/ready handshake, and redirect flush from EX.
// Optional macro STAGEIF_BYPASS_EN: when the queue is empty the fetched
// instruction is presented to decode in the same cycle.
// Handshake: an entry transfers on a cycle where o_valid && i_ready; o_valid
// never depends on i_ready, and a redirect suppresses both valid and transfer.
module stageif_q
    import stageif_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_redirect,
    input  logic [XLEN-1:0]  i_redirect_pc,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic [ILEN-1:0]  i_imem_inst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ILEN-1:0]  o_instr,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc_four,
    output logic [CNT_W-1:0] o_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           wdata;
    logic             q_valid;
    logic             pop;
    logic             push;
    logic             fifo_push;
    logic             unused_bits;

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_bits = ^i_redirect_pc[1:0];

    assign q_valid = (count != '0);
    assign pop     = q_valid && i_ready && !i_redirect;
    assign push    = i_enable && !i_redirect && ((count < CNT_W'(DEPTH)) || pop);
    assign wdata   = '{pc: pc_q, instr: i_imem_inst};

`ifdef STAGEIF_BYPASS_EN
    logic bypass;
    // Empty queue: the fetch goes straight to decode; it is only written when
    // decode does not take it this cycle.
    assign bypass    = !q_valid && i_enable && !i_redirect;
    assign fifo_push = push && !(bypass && i_ready);
`else
    assign fifo_push = push;
`endif

    // PC next-state: redirect first, otherwise advance on every fetch taken.
    always_comb begin
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    // PC register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (fifo_push),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .i_wdata (wdata),
        .o_head  (head),
        .o_count (count)
    );

    // Decode-side outputs: queue head, or the live fetch when bypassing.
    always_comb begin
        o_valid = q_valid && !i_redirect;
        o_instr = head.instr;
        o_pc    = head.pc;
`ifdef STAGEIF_BYPASS_EN
        if (bypass) begin
            o_valid = 1'b1;
            o_instr = i_imem_inst;
            o_pc    = pc_q;
        end
`endif
    end

    assign o_pc_four   = o_pc + XLEN'(PC_STEP);
    assign o_imem_addr = pc_q;
    assign o_count     = count;

endmodule

// File: tb/tb_stageif_q.sv
// Bench for stageif_q: a reference model fills an expected queue as fetches
// happen and checks each entry as decode takes it; scenario tasks add
// targeted checks. Works with or without STAGEIF_BYPASS_EN.
module tb_stageif_q;

`ifdef STAGEIF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_ready;
    logic [31:0] i_imem_inst;
    logic [31:0] salt;

    logic [31:0] o_imem_addr, o_instr, o_pc, o_pc_four;
    logic        o_valid;
    logic [2:0]  o_count;

    logic [31:0] r_imem_addr, r_instr, r_pc, r_pc_four;
    logic        r_valid;
    logic [2:0]  r_count;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;

    // clock / memory model
    always #5 clk = ~clk;
    assign i_imem_inst = o_imem_addr ^ salt;

    stageif_q #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_addr(o_imem_addr), .i_imem_inst(i_imem_inst),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
        .o_pc(o_pc), .o_pc_four(o_pc_four), .o_count(o_count)
    );

    stageif_q #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h100)) dut_r (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_addr(r_imem_addr), .i_imem_inst(i_imem_inst),
        .o_valid(r_valid), .i_ready(i_ready), .o_instr(r_instr),
        .o_pc(r_pc), .o_pc_four(r_pc_four), .o_count(r_count)
    );

    // scoreboard: model of the fetch stage, sampled on the falling edge
    logic [31:0] m_fetch;
    logic [63:0] m_head;
    logic        m_byp, m_valid, m_pop;
    int          m_cnt;

    always @(negedge clk) begin
        if (i_reset !== 1'b0) begin
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            m_fetch = model_pc ^ salt;
            m_byp   = 1'b0;
            if (BYP && exp_q.size() == 0 && i_enable && !i_redirect) begin
                m_byp = 1'b1;
                exp_q.push_back({model_pc, m_fetch});
            end
            m_cnt   = exp_q.size() - (m_byp ? 1 : 0);
            m_valid = !i_redirect && (exp_q.size() != 0);
            vectors++;
            if (o_imem_addr !== model_pc) begin
                miscompares++;
                $display("FAIL sb_addr: got %h want %h @%0t", o_imem_addr, model_pc, $time);
            end
            vectors++;
            if (o_valid !== m_valid) begin
                miscompares++;
                $display("FAIL sb_valid: got %b want %b @%0t", o_valid, m_valid, $time);
            end
            vectors++;
            if (o_count !== m_cnt[2:0]) begin
                miscompares++;
                $display("FAIL sb_count: got %0d want %0d @%0t", o_count, m_cnt, $time);
            end
            m_pop = m_valid && i_ready;
            if (m_pop) begin
                m_head = exp_q.pop_front();
                vectors++;
                if (o_pc !== m_head[63:32] || o_instr !== m_head[31:0] ||
                    o_pc_four !== m_head[63:32] + 32'd4) begin
                    miscompares++;
                    $display("FAIL sb_head: got pc %h instr %h pc4 %h want pc %h instr %h @%0t",
                             o_pc, o_instr, o_pc_four, m_head[63:32], m_head[31:0], $time);
                end
            end
            if (i_redirect) begin
                exp_q.delete();
                model_pc = {i_redirect_pc[31:2], 2'b00};
            end else if (i_enable && (m_cnt < DEPTH || m_pop)) begin
                if (!m_byp) exp_q.push_back({model_pc, m_fetch});
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // driver helpers
    task automatic do_reset();
        i_reset = 1'b1; i_enable = 1'b0; i_ready = 1'b0; i_redirect = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_enable = 1'b0; i_ready = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = '0; salt = '0;
        #3;
        vectors++;
        if (r_imem_addr !== 32'h100 || r_valid !== 1'b0 || r_count !== 3'd0 || r_pc_four !== 32'd4) begin
            miscompares++;
            $display("FAIL reset_r: addr %h valid %b count %0d pc4 %h want 100 0 0 4",
                     r_imem_addr, r_valid, r_count, r_pc_four);
        end
        vectors++;
        if (o_imem_addr !== 32'h0 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: addr %h pc %h instr %h valid %b want 0 0 0 0",
                     o_imem_addr, o_pc, o_instr, o_valid);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_streaming();
        int first;
        first = BYP ? 0 : 1;
        salt = '0; i_enable = 1'b1; i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (i >= first) begin
                vectors++;
                if (o_valid !== 1'b1 || o_pc !== 32'((i - first) * 4) || o_instr !== o_pc ||
                    o_count !== (BYP ? 3'd0 : 3'd1)) begin
                    miscompares++;
                    $display("FAIL stream[%0d]: valid %b pc %h instr %h count %0d want pc %h",
                             i, o_valid, o_pc, o_instr, o_count, (i - first) * 4);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        i_enable = 1'b1; i_ready = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        vectors++;
        if (o_count !== 3'd4 || o_imem_addr !== 32'h10 || o_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_full: count %0d addr %h pc %h want 4 10 0", o_count, o_imem_addr, o_pc);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (o_count !== 3'd4 || o_valid !== 1'b1 || o_pc !== 32'(k * 4) ||
                o_imem_addr !== 32'(16 + k * 4)) begin
                miscompares++;
                $display("FAIL bp_stream[%0d]: count %0d pc %h addr %h want 4 %h %h",
                         k, o_count, o_pc, o_imem_addr, k * 4, 16 + k * 4);
            end
            @(posedge clk); #3;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        i_enable = 1'b1; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (o_count !== 3'd3) begin
            miscompares++;
            $display("FAIL redir_fill: count %0d want 3", o_count);
        end
        i_redirect = 1'b1; i_redirect_pc = 32'h203;
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_valid: got %b want 0", o_valid);
        end
        @(posedge clk); #1;
        i_redirect = 1'b0;
        #2;
        vectors++;
        if (o_count !== 3'd0 || o_imem_addr !== 32'h200 || o_valid !== BYP) begin
            miscompares++;
            $display("FAIL redir_n1: count %0d addr %h valid %b want 0 200 %b",
                     o_count, o_imem_addr, o_valid, BYP);
        end
        @(posedge clk); #3;
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instr !== 32'h200) begin
            miscompares++;
            $display("FAIL redir_n2: valid %b pc %h instr %h want 1 200 200", o_valid, o_pc, o_instr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        i_enable = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        i_redirect = 1'b0;
        #2;
        vectors++;
        if (o_imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h want fffffffc", o_imem_addr);
        end
        @(posedge clk); #3;
        vectors++;
        if (o_imem_addr !== 32'h0 || o_pc !== 32'hFFFF_FFFC || o_pc_four !== 32'h0 || o_count !== 3'd1) begin
            miscompares++;
            $display("FAIL wrap_head: addr %h pc %h pc4 %h count %0d want 0 fffffffc 0 1",
                     o_imem_addr, o_pc, o_pc_four, o_count);
        end
        i_ready = 1'b1;
        @(posedge clk); #3;
        vectors++;
        if (o_pc !== 32'h0 || o_pc_four !== 32'h4) begin
            miscompares++;
            $display("FAIL wrap_next: pc %h pc4 %h want 0 4", o_pc, o_pc_four);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_enable = 1'b1; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (o_count !== 3'd3) begin
            miscompares++;
            $display("FAIL areset_fill: count %0d want 3", o_count);
        end
        #1;
        i_reset = 1'b1;
        #1;
        vectors++;
        if (o_count !== 3'd0 || o_valid !== 1'b0 || o_imem_addr !== 32'h0 || o_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL areset: count %0d valid %b addr %h pc %h want 0 0 0 0",
                     o_count, o_valid, o_imem_addr, o_pc);
        end
        @(posedge clk); #1;
        i_reset = 1'b0; i_enable = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        salt = $urandom;
        for (int n = 0; n < 300; n++) begin
            i_enable      = ($urandom_range(0, 3) != 0);
            i_ready       = $urandom_range(0, 1);
            i_redirect    = ($urandom_range(0, 15) == 0);
            i_redirect_pc = $urandom;
            @(posedge clk); #1;
        end
        i_enable = 1'b0; i_ready = 1'b1; i_redirect = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
